color_sweep_scheduler: RTL and testbench
========================================

COLOR_SWEEP_SCHEDULER -- requirements
Module: color_sweep_scheduler

Interface
REQ-001 SHALL have parameter NUM_COLORS, default 2, the number of graph colors (p-bit update phases) per sweep, range 2..8.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1, the idle cycles after each color update before the next phase, range 0..15.
REQ-003 SHALL have parameter SWEEP_W, default 16, the width of the sweep counters.
REQ-004 SHALL have port sample_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a run request sampled only in IDLE.
REQ-007 SHALL have port stop, input, 1, a request to end the run at the next sweep boundary.
REQ-008 SHALL have port num_sweeps, input, SWEEP_W, the sweeps per run, latched at start; 0 means free-run.
REQ-009 SHALL have port sample_interval, input, 8, the sweeps between samples, latched at start; 0 is treated as 1.
REQ-010 SHALL have port rng_adv, output, 1, a one-cycle strobe that advances the active color's LFSR.
REQ-011 SHALL have port color_en, output, NUM_COLORS, a one-hot update strobe for the p-bits of color c.
REQ-012 SHALL have port sample_valid, output, 1, which is high while the spin snapshot is stable for capture.
REQ-013 SHALL have port sample_ready, input, 1, which accepts the snapshot when high together with sample_valid.
REQ-014 SHALL have port busy, output, 1, which is high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse at the end of the run.
REQ-016 SHALL have port sweep_count, output, SWEEP_W, the number of completed sweeps in the current run.

Function
REQ-017 SHALL implement the FSM states IDLE, RNG, UPDATE, SETTLE, SAMPLE and DONE, with a color index c running from 0 to NUM_COLORS-1.
REQ-018 IDLE SHALL move to RNG when start is 1; at that transition it SHALL set c=0, clear sweep_count, and latch num_sweeps and sample_interval.
REQ-019 RNG SHALL last 1 cycle with rng_adv=1, then move to UPDATE.
REQ-020 UPDATE SHALL last 1 cycle with color_en[c]=1 and all other color_en bits 0.
REQ-021 After UPDATE, the FSM SHALL move to SETTLE if SETTLE_CYCLES>0, or else take the phase exit in REQ-022 directly.
REQ-022 Phase exit: if c<NUM_COLORS-1, the FSM SHALL increment c and go to RNG; otherwise it is at a sweep boundary.
REQ-023 At a sweep boundary, sweep_count SHALL increment, wrapping modulo 2^SWEEP_W in free-run mode.
REQ-024 A sample SHALL be due at every sample_interval-th completed sweep; this uses a separate down-counter, independent of sweep_count wrap.
REQ-025 At a sweep boundary with a sample due, the FSM SHALL enter SAMPLE.
REQ-026 In SAMPLE, sample_valid SHALL stay 1 until a cycle with sample_ready=1; no color_en or rng_adv SHALL fire meanwhile, giving full backpressure.
REQ-027 After the boundary (and after SAMPLE if taken), the FSM SHALL go to DONE if (num_sweeps!=0 and sweep_count==num_sweeps) or stop_pending; otherwise it SHALL set c=0 and go to RNG.
REQ-028 DONE SHALL pulse done for 1 cycle, clear stop_pending and return to IDLE; sweep_count SHALL hold its value until the next start.
REQ-029 stop asserted in any state other than IDLE SHALL set stop_pending; the current sweep and any due sample handshake SHALL complete first.
REQ-030 stop is ignored in IDLE; start and stop in the same IDLE cycle SHALL run exactly one sweep and then finish.
REQ-031 start while busy SHALL be ignored.
REQ-032 Sweep length without stalls SHALL be NUM_COLORS*(2+SETTLE_CYCLES) cycles; with defaults this is 6.
REQ-033 At most one of rng_adv and color_en SHALL be high in any cycle.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE with c=0, rng_adv=0, color_en=0, sample_valid=0, busy=0, done=0, sweep_count=0, stop_pending=0 and the interval counter=0.
REQ-035 Reset mid-run SHALL abort without a done pulse; the first start after rst_n deasserts begins a clean run.

Structure
REQ-036 The FSM state enum and constants MAX_COLORS=8 and MAX_SETTLE=15 SHALL live in shared package ising_pkg.
REQ-037 The single sub-module SHALL be phase_timer, which counts the SETTLE cycles; all other logic is inline.

Verification
REQ-038 Defaults with num_sweeps=3, sample_interval=1 and sample_ready tied 1: rng_adv/color_en pattern SHALL be RNG,EN0,settle,RNG,EN1,settle, 3 sample handshakes, done at cycle 18+3, sweep_count=3.
REQ-039 num_sweeps=2, sample_interval=1, sample_ready held 0 for 5 cycles at the first sample: sample_valid SHALL stay high 6 cycles, strobes freeze, done SHALL be delayed by 5 cycles.
REQ-040 num_sweeps=0, stop pulsed mid-sweep 4: sweep 4 SHALL complete, done SHALL pulse, sweep_count=4.
REQ-041 num_sweeps=10, sample_interval=4: samples SHALL occur after sweeps 4 and 8 only.
REQ-042 rst_n=0 during UPDATE: outputs SHALL go to 0 immediately, no done, and a fresh start SHALL restart from c=0.
REQ-043 Start and stop in the same cycle with NUM_COLORS=3 and SETTLE_CYCLES=0: one 6-cycle sweep, then done.

Source files
------------

// File: rtl/ising_pkg.sv
// Shared FSM state encoding and sizing constants for the p-bit sweep scheduler.
package ising_pkg;

  localparam int unsigned MAX_COLORS = 8;
  localparam int unsigned MAX_SETTLE = 15;
  localparam int unsigned COLOR_W    = $clog2(MAX_COLORS);
  localparam int unsigned SETTLE_W   = $clog2(MAX_SETTLE + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RNG,
    ST_UPDATE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } sweep_state_e;

endpackage

// File: rtl/phase_timer.sv
// Counts the settle cycles that follow each color update.
module phase_timer
  import ising_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic last_o
);

  localparam logic [SETTLE_W-1:0] LAST = SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  // Count while enabled; restart from zero on the final cycle or when idle.
  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Settle counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/color_sweep_scheduler.sv
// Sequences graph-colored p-bit updates: per color an RNG advance, an update
// strobe and optional settle time; samples the spins every N sweeps.
module color_sweep_scheduler
  import ising_pkg::*;
#(
  parameter int unsigned NUM_COLORS    = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned SWEEP_W       = 16
) (
  input  logic                  sample_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [SWEEP_W-1:0]    num_sweeps,
  input  logic [7:0]            sample_interval,
  output logic                  rng_adv,
  output logic [NUM_COLORS-1:0] color_en,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  done,
  output logic [SWEEP_W-1:0]    sweep_count
);

  localparam logic [COLOR_W-1:0] C_LAST = COLOR_W'(NUM_COLORS - 1);

  sweep_state_e        state_q, state_d;
  logic [COLOR_W-1:0]  c_q, c_d;
  logic [SWEEP_W-1:0]  sweep_q, sweep_d;
  logic [SWEEP_W-1:0]  nsweeps_q, nsweeps_d;
  logic [7:0]          intv_q, intv_d;
  logic [7:0]          icnt_q, icnt_d;
  logic                stop_q, stop_d;
  logic                settle_last;
  logic                phase_exit;
  logic [SWEEP_W-1:0]  sweep_inc;
  logic [7:0]          intv_eff;

  phase_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_phase_timer (
    .clk_i (sample_clk),
    .rst_ni(rst_n),
    .en_i  (state_q == ST_SETTLE),
    .last_o(settle_last)
  );

  assign sweep_inc = sweep_q + 1'b1;
  assign intv_eff  = (sample_interval == 8'd0) ? 8'd1 : sample_interval;
  assign phase_exit = ((state_q == ST_UPDATE) && (SETTLE_CYCLES == 0)) ||
                      ((state_q == ST_SETTLE) && settle_last);

  // Next-state logic; the phase exit is handled after the case because it can
  // originate from either UPDATE or SETTLE depending on SETTLE_CYCLES.
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    sweep_d   = sweep_q;
    nsweeps_d = nsweeps_q;
    intv_d    = intv_q;
    icnt_d    = icnt_q;
    stop_d    = stop_q | ((state_q != ST_IDLE) && stop);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RNG;
          c_d       = '0;
          sweep_d   = '0;
          nsweeps_d = num_sweeps;
          intv_d    = intv_eff;
          icnt_d    = intv_eff;
          stop_d    = stop;
        end
      end
      ST_RNG:    state_d = ST_UPDATE;
      ST_UPDATE: if (SETTLE_CYCLES != 0) state_d = ST_SETTLE;
      ST_SETTLE: ;
      ST_SAMPLE: begin
        if (sample_ready) begin
          c_d = '0;
          if (((nsweeps_q != '0) && (sweep_q == nsweeps_q)) || stop_q || stop) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RNG;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (phase_exit) begin
      if (c_q != C_LAST) begin
        c_d     = c_q + 1'b1;
        state_d = ST_RNG;
      end else begin
        sweep_d = sweep_inc;
        c_d     = '0;
        if (icnt_q <= 8'd1) begin
          icnt_d  = intv_q;
          state_d = ST_SAMPLE;
        end else begin
          icnt_d = icnt_q - 8'd1;
          if (((nsweeps_q != '0) && (sweep_inc == nsweeps_q)) || stop_q || stop) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RNG;
          end
        end
      end
    end
  end

  // State and run-context registers.
  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      c_q       <= '0;
      sweep_q   <= '0;
      nsweeps_q <= '0;
      intv_q    <= '0;
      icnt_q    <= '0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      sweep_q   <= sweep_d;
      nsweeps_q <= nsweeps_d;
      intv_q    <= intv_d;
      icnt_q    <= icnt_d;
      stop_q    <= stop_d;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    rng_adv      = (state_q == ST_RNG);
    sample_valid = (state_q == ST_SAMPLE);
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    color_en     = '0;
    for (int unsigned i = 0; i < NUM_COLORS; i++) begin
      color_en[i] = (state_q == ST_UPDATE) && (c_q == COLOR_W'(i));
    end
  end

  assign sweep_count = sweep_q;

endmodule

// File: tb/tb_color_sweep_scheduler.sv
module tb_color_sweep_scheduler;

  logic        sample_clk = 1'b0;
  logic        rst_n, start, stop, start2, stop2, sample_ready;
  logic [15:0] num_sweeps;
  logic [7:0]  sample_interval;

  logic        rng_adv, sample_valid, busy, done;
  logic [1:0]  color_en;
  logic [15:0] sweep_count;
  logic        rng_adv2, sample_valid2, busy2, done2;
  logic [2:0]  color_en2;
  logic [15:0] sweep_count2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rdy;
    logic        stp;
    logic        stt;
    logic        rng;
    logic [2:0]  en;
    logic        sv;
    logic        bz;
    logic        dn;
    logic [15:0] cnt;
  } item_t;

  item_t       sb[$];
  int unsigned exp_cnt;

  always #5 sample_clk = ~sample_clk;

  color_sweep_scheduler dut (
    .sample_clk     (sample_clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .num_sweeps     (num_sweeps),
    .sample_interval(sample_interval),
    .rng_adv        (rng_adv),
    .color_en       (color_en),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .busy           (busy),
    .done           (done),
    .sweep_count    (sweep_count)
  );

  color_sweep_scheduler #(
    .NUM_COLORS   (3),
    .SETTLE_CYCLES(0),
    .SWEEP_W      (16)
  ) dut2 (
    .sample_clk     (sample_clk),
    .rst_n          (rst_n),
    .start          (start2),
    .stop           (stop2),
    .num_sweeps     (num_sweeps),
    .sample_interval(sample_interval),
    .rng_adv        (rng_adv2),
    .color_en       (color_en2),
    .sample_valid   (sample_valid2),
    .sample_ready   (sample_ready),
    .busy           (busy2),
    .done           (done2),
    .sweep_count    (sweep_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic rng, input logic [2:0] en, input logic sv, input logic dn,
                     input logic rdy, input logic stp, input logic stt);
    item_t it;
    it.rdy = rdy; it.stp = stp; it.stt = stt;
    it.rng = rng; it.en = en; it.sv = sv; it.bz = 1'b1; it.dn = dn;
    it.cnt = exp_cnt[15:0];
    sb.push_back(it);
  endtask

  // One sweep of the default 2-color, 1-settle instance: RNG, EN, settle per color.
  task automatic sweep2(input int stop_pos, input int start_pos);
    for (int i = 0; i < 2; i++) begin
      add(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, stop_pos == 3*i,     start_pos == 3*i);
      add(1'b0, 3'(1 << i), 1'b0, 1'b0, 1'b1, stop_pos == 3*i+1, start_pos == 3*i+1);
      add(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, stop_pos == 3*i+2,   start_pos == 3*i+2);
    end
    exp_cnt++;
  endtask

  task automatic sample(input int stall);
    for (int s = 0; s < stall; s++) add(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic fin();
    add(1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Called at a negedge; leaves at the negedge after the start edge.
  task automatic do_start(input bit use2, input logic [15:0] ns, input logic [7:0] iv, input logic with_stop);
    num_sweeps = ns;
    sample_interval = iv;
    if (use2) begin start2 = 1'b1; stop2 = with_stop; end
    else      begin start  = 1'b1; stop  = with_stop; end
    @(negedge sample_clk);
    start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
  endtask

  // Pops one expected cycle per negedge, drives that cycle's inputs, compares outputs.
  task automatic run_trace(input bit use2, input string name);
    item_t       it;
    logic [22:0] obs;
    int          idx = 0;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      sample_ready = it.rdy;
      if (use2) stop2 = it.stp; else stop = it.stp;
      start = it.stt;
      obs = use2 ? {rng_adv2, color_en2, sample_valid2, busy2, done2, sweep_count2}
                 : {rng_adv, 1'b0, color_en, sample_valid, busy, done, sweep_count};
      check($sformatf("%s[%0d]", name, idx), 32'(obs),
            32'({it.rng, it.en, it.sv, it.bz, it.dn, it.cnt}));
      idx++;
      @(negedge sample_clk);
    end
    stop = 1'b0; stop2 = 1'b0; start = 1'b0; sample_ready = 1'b1;
  endtask

  task automatic check_idle(input string name, input logic [15:0] cnt);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_count"}, 32'(sweep_count), 32'(cnt));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    sample_ready = 1'b1; num_sweeps = '0; sample_interval = '0;
    repeat (2) @(negedge sample_clk);
    check("reset_outs", 32'({rng_adv, color_en, sample_valid, busy, done, sweep_count}), 32'd0);
    check("reset_outs2", 32'({rng_adv2, color_en2, sample_valid2, busy2, done2, sweep_count2}), 32'd0);
    rst_n = 1'b1;
    @(negedge sample_clk);

    // Three sweeps, sample each sweep, ready always high: done lands at cycle 21.
    exp_cnt = 0;
    do_start(1'b0, 16'd3, 8'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin sweep2(-1, -1); sample(0); end
    fin();
    run_trace(1'b0, "basic");
    check_idle("basic_end", 16'd3);

    // Backpressure: first sample held off for 5 cycles.
    exp_cnt = 0;
    do_start(1'b0, 16'd2, 8'd1, 1'b0);
    sweep2(-1, -1); sample(5); sweep2(-1, -1); sample(0); fin();
    run_trace(1'b0, "stall");
    check_idle("stall_end", 16'd2);

    // Free-run, sample every 3rd sweep, stop during sweep 4.
    exp_cnt = 0;
    do_start(1'b0, 16'd0, 8'd3, 1'b0);
    sweep2(-1, -1); sweep2(-1, -1); sweep2(-1, -1); sample(0);
    sweep2(2, -1); fin();
    run_trace(1'b0, "stop");
    check_idle("stop_end", 16'd4);

    // Ten sweeps, interval 4, with a start pulse while busy that must be ignored.
    exp_cnt = 0;
    do_start(1'b0, 16'd10, 8'd4, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      sweep2(-1, (k == 2) ? 1 : -1);
      if (k == 4 || k == 8) sample(0);
    end
    fin();
    run_trace(1'b0, "intv4");
    check_idle("intv4_end", 16'd10);

    // Interval 0 acts as 1; reset asserted mid UPDATE of sweep 2.
    exp_cnt = 0;
    do_start(1'b0, 16'd0, 8'd0, 1'b0);
    sweep2(-1, -1); sample(0);
    add(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_trace(1'b0, "prerst");
    check("prerst_update", 32'({color_en, sweep_count}), 32'({2'b01, 16'd1}));
    #1 rst_n = 1'b0;
    #1 check("rst_async", 32'({rng_adv, color_en, sample_valid, busy, done, sweep_count}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge sample_clk);
      check($sformatf("rst_hold[%0d]", k), 32'({busy, done}), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge sample_clk);
    stop = 1'b1;
    @(negedge sample_clk);
    stop = 1'b0;
    check("idle_stop_ignored", 32'(busy), 32'd0);
    exp_cnt = 0;
    do_start(1'b0, 16'd2, 8'd2, 1'b0);
    sweep2(-1, -1); sweep2(-1, -1); sample(0); fin();
    run_trace(1'b0, "restart");
    check_idle("restart_end", 16'd2);

    // 3 colors, no settle: start with stop gives one 6-cycle sweep then done.
    exp_cnt = 0;
    do_start(1'b1, 16'd0, 8'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      add(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b0, 3'(1 << i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    exp_cnt = 1;
    fin();
    run_trace(1'b1, "c3");
    check("c3_end", 32'({busy2, done2, sweep_count2}), 32'({2'b00, 16'd1}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
